// File: rtl/alu_control_decoder.sv
// Registered ALU control decoder: maps {AluOp, Funct} to a 5-bit ALU operation select.
// Optional macro ALU_CTRL_ILLEGAL_FLAG_EN adds a registered Illegal output flagging NOP decodes.
`timescale 1ns/1ps

module alu_control_decoder #(
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 5
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [OP_W-1:0]    AluOp,
  input  logic [FUNCT_W-1:0] Funct,
  output logic [CTRL_W-1:0]  ALUControl
`ifdef ALU_CTRL_ILLEGAL_FLAG_EN
  ,
  output logic               Illegal
`endif
);

  typedef enum logic [4:0] {
    ALU_ADD     = 5'd0,
    ALU_ADDU    = 5'd1,
    ALU_SUB     = 5'd2,
    ALU_SUBU    = 5'd3,
    ALU_MULT    = 5'd4,
    ALU_MULTU   = 5'd5,
    ALU_AND     = 5'd6,
    ALU_OR      = 5'd7,
    ALU_NOR     = 5'd8,
    ALU_XOR     = 5'd9,
    ALU_SLL     = 5'd10,
    ALU_SRL     = 5'd11,
    ALU_SLLV    = 5'd12,
    ALU_SLT     = 5'd13,
    ALU_SLTU    = 5'd14,
    ALU_MOVN    = 5'd15,
    ALU_MOVZ    = 5'd16,
    ALU_ROTRV   = 5'd17,
    ALU_SRA     = 5'd18,
    ALU_SRAV    = 5'd19,
    ALU_MUL     = 5'd20,
    ALU_MADD    = 5'd21,
    ALU_MSUB    = 5'd22,
    ALU_SEH_SEB = 5'd23,
    ALU_NOP     = 5'd31
  } alu_ctrl_e;

  // Operation classes issued by the main controller
  localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUBI  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ORI   = 4'b0011;
  localparam logic [OP_W-1:0] OP_ANDI  = 4'b0100;
  localparam logic [OP_W-1:0] OP_XORI  = 4'b0101;
  localparam logic [OP_W-1:0] OP_NORI  = 4'b0110;
  localparam logic [OP_W-1:0] OP_ADDIU = 4'b0111;
  localparam logic [OP_W-1:0] OP_SUBIU = 4'b1000;
  localparam logic [OP_W-1:0] OP_MULTI = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLTI  = 4'b1010;
  localparam logic [OP_W-1:0] OP_SLTIU = 4'b1011;
  localparam logic [OP_W-1:0] OP_MULC  = 4'b1100;
  localparam logic [OP_W-1:0] OP_SEXT  = 4'b1101;

  function automatic alu_ctrl_e decode_rtype(input logic [FUNCT_W-1:0] f);
    alu_ctrl_e r;
    r = ALU_NOP;
    case (f)
      6'b100000: r = ALU_ADD;
      6'b100001: r = ALU_ADDU;
      6'b100010: r = ALU_SUB;
      6'b011000: r = ALU_MULT;
      6'b010001: r = ALU_MULTU;
      6'b100100: r = ALU_AND;
      6'b100101: r = ALU_OR;
      6'b100111: r = ALU_NOR;
      6'b100110: r = ALU_XOR;
      6'b000000: r = ALU_SLL;
      6'b000010: r = ALU_SRL;
      6'b000100: r = ALU_SLLV;
      6'b101010: r = ALU_SLT;
      6'b101011: r = ALU_SLTU;
      6'b001011: r = ALU_MOVN;
      6'b001010: r = ALU_MOVZ;
      6'b000110: r = ALU_ROTRV;
      6'b000011: r = ALU_SRA;
      6'b000111: r = ALU_SRAV;
      default:   r = ALU_NOP;
    endcase
    return r;
  endfunction

  function automatic alu_ctrl_e decode_mulc(input logic [FUNCT_W-1:0] f);
    alu_ctrl_e r;
    r = ALU_NOP;
    case (f)
      6'b000010: r = ALU_MUL;
      6'b000000: r = ALU_MADD;
      6'b000100: r = ALU_MSUB;
      default:   r = ALU_NOP;
    endcase
    return r;
  endfunction

  alu_ctrl_e ctrl_d, ctrl_q;
  logic      illegal_d, illegal_q;

  always_comb begin
    ctrl_d = ALU_NOP;
    case (AluOp)
      OP_RTYPE: ctrl_d = decode_rtype(Funct);
      OP_ADDI:  ctrl_d = ALU_ADD;
      OP_SUBI:  ctrl_d = ALU_SUB;
      OP_ORI:   ctrl_d = ALU_OR;
      OP_ANDI:  ctrl_d = ALU_AND;
      OP_XORI:  ctrl_d = ALU_XOR;
      OP_NORI:  ctrl_d = ALU_NOR;
      OP_ADDIU: ctrl_d = ALU_ADDU;
      OP_SUBIU: ctrl_d = ALU_SUBU;
      OP_MULTI: ctrl_d = ALU_MULTU;
      OP_SLTI:  ctrl_d = ALU_SLT;
      OP_SLTIU: ctrl_d = ALU_SLTU;
      OP_MULC:  ctrl_d = decode_mulc(Funct);
      OP_SEXT:  ctrl_d = ALU_SEH_SEB;
      default:  ctrl_d = ALU_NOP;
    endcase
    // NOP is only ever reached through an unmatched decode
    illegal_d = (ctrl_d == ALU_NOP);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctrl_q    <= ALU_ADD;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign ALUControl = ctrl_q;

`ifdef ALU_CTRL_ILLEGAL_FLAG_EN
  assign Illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_control_decoder.sv
// Scoreboard bench for alu_control_decoder: directed plan plus random {AluOp, Funct} against a table model.
`timescale 1ns/1ps

module tb_alu_control_decoder;

  logic       Clk;
  logic       Rst;
  logic [3:0] AluOp;
  logic [5:0] Funct;
  logic [4:0] ALUControl;
`ifdef ALU_CTRL_ILLEGAL_FLAG_EN
  logic       Illegal;
`endif

  alu_control_decoder dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .AluOp      (AluOp),
    .Funct      (Funct),
    .ALUControl (ALUControl)
`ifdef ALU_CTRL_ILLEGAL_FLAG_EN
    ,
    .Illegal    (Illegal)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int op;
    int funct;
    int ctrl;
  } exp_t;

  exp_t exp_q[$];

  // Reference tables taken straight from the opcode listing
  int r_funct[19] = '{6'b100000, 6'b100001, 6'b100010, 6'b011000, 6'b010001,
                      6'b100100, 6'b100101, 6'b100111, 6'b100110,
                      6'b000000, 6'b000010, 6'b000100, 6'b101010, 6'b101011,
                      6'b001011, 6'b001010, 6'b000110, 6'b000011, 6'b000111};
  int r_ctrl[19]  = '{0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
  int m_funct[3]  = '{6'b000010, 6'b000000, 6'b000100};
  int m_ctrl[3]   = '{20, 21, 22};
  int imm_ctrl[11] = '{0, 2, 7, 6, 9, 8, 1, 3, 5, 13, 14};

  function automatic int model(int op, int f);
    if (op == 0) begin
      for (int i = 0; i < 19; i++) if (r_funct[i] == f) return r_ctrl[i];
      return 31;
    end
    if (op >= 1 && op <= 11) return imm_ctrl[op-1];
    if (op == 12) begin
      for (int i = 0; i < 3; i++) if (m_funct[i] == f) return m_ctrl[i];
      return 31;
    end
    if (op == 13) return 23;
    return 31;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drives inputs, queues the response, advances one cycle
  task automatic applyStimulus(input int op, input int f);
    exp_t e;
    AluOp = op[3:0];
    Funct = f[5:0];
    if (Rst) begin
      e.op = op;
      e.funct = f;
      e.ctrl = model(op, f);
      exp_q.push_back(e);
    end
    @(negedge Clk);
  endtask

  // Monitor: every captured edge presents one queued response
  always begin
    exp_t e;
    @(posedge Clk);
    #2;
    if (Rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput($sformatf("decode op=%0d funct=%b", e.op, e.funct[5:0]), int'(ALUControl), e.ctrl);
`ifdef ALU_CTRL_ILLEGAL_FLAG_EN
      checkOutput($sformatf("illegal op=%0d funct=%b", e.op, e.funct[5:0]), int'(Illegal), int'(e.ctrl == 31));
`endif
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waits;
    int op;
    int f;
    Rst = 1'b1;
    AluOp = 4'b0000;
    Funct = 6'b100010;
    #1 Rst = 1'b0;

    repeat (3) begin
      @(negedge Clk);
      checkOutput("reset_hold", int'(ALUControl), 0);
`ifdef ALU_CTRL_ILLEGAL_FLAG_EN
      checkOutput("reset_illegal", int'(Illegal), 0);
`endif
    end

    Rst = 1'b1;
    applyStimulus(0, 6'b100010);

    for (int i = 0; i < 19; i++) applyStimulus(0, r_funct[i]);

    applyStimulus(12, 6'b000010);
    applyStimulus(12, 6'b000000);
    applyStimulus(12, 6'b000100);
    applyStimulus(12, 6'b111111);

    for (int op_i = 1; op_i <= 11; op_i++) applyStimulus(op_i, 6'b100000);
    applyStimulus(1, 6'b100101);

    applyStimulus(13, 6'b100000);
    applyStimulus(0, 6'b100000);
    applyStimulus(15, 6'b000000);
    applyStimulus(14, 6'b101010);
    applyStimulus(0, 6'b111111);

    // Async reset between edges while the output shows XOR
    applyStimulus(5, 6'b000000);
    @(posedge Clk);
    #3;
    checkOutput("pre_async_reset", int'(ALUControl), 9);
    Rst = 1'b0;
    #1;
    checkOutput("async_reset", int'(ALUControl), 0);
    @(negedge Clk);
    applyStimulus(0, 6'b100110);
    checkOutput("reset_mid_hold", int'(ALUControl), 0);
    Rst = 1'b1;
    applyStimulus(0, 6'b100110);

    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) f = r_funct[$urandom_range(0, 18)];
      else f = int'($urandom_range(0, 63));
      applyStimulus(op, f);
    end

    waits = 0;
    while (exp_q.size() != 0 && waits < 5) begin
      @(negedge Clk);
      waits++;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
